// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - valid/ready FIFO controller driving an external sync-write/async-read RAM
// Capacity is the RAM depth plus the registered output stage.
module fifo_ram_ctrl #(
  parameter int width     = 8,
  parameter int widthad   = 4,
  parameter int afull_lvl = 2**widthad - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclr,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [width-1:0]   wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [width-1:0]   rd_data,
  output logic [widthad:0]   usedw,
  output logic               full,
  output logic               almost_full,
  output logic [widthad-1:0] ram_wraddress,
  output logic               ram_wren,
  output logic [width-1:0]   ram_data,
  output logic [widthad-1:0] ram_rdaddress,
  input  logic [width-1:0]   ram_q
);

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [widthad:0] AFULL_LVL = (widthad+1)'(afull_lvl);

  state_t             state_q, state_d;
  logic [widthad:0]   wr_ptr_q, wr_ptr_d;
  logic [widthad:0]   rd_ptr_q, rd_ptr_d;
  logic [widthad:0]   usedw_q, usedw_d;
  logic [width-1:0]   rd_data_q, rd_data_d;
  logic               ram_empty, ram_full, wr_acc, rd_take, load;

  // The MSB of each pointer is a wrap bit, distinguishing full from empty.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[widthad-1:0] == rd_ptr_q[widthad-1:0]) &&
                     (wr_ptr_q[widthad] != rd_ptr_q[widthad]);

  assign wr_ready = ~ram_full & ~sclr;
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_valid = (state_q == S_HOLD);
  assign rd_take  = rd_valid & rd_ready & ~sclr;
  assign load     = ~ram_empty & (~rd_valid | rd_ready) & ~sclr;

  assign full          = ~wr_ready;
  assign almost_full   = (usedw_q >= AFULL_LVL);
  assign usedw         = usedw_q;
  assign rd_data       = rd_data_q;
  // The RAM must never see a write strobe while the controller is held in reset.
  assign ram_wren      = wr_acc & rst_n;
  assign ram_data      = wr_data;
  assign ram_wraddress = wr_ptr_q[widthad-1:0];
  assign ram_rdaddress = rd_ptr_q[widthad-1:0];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    rd_data_d = rd_data_q;
    if (sclr) begin
      state_d  = S_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (load) begin
        rd_data_d = ram_q;
        rd_ptr_d  = rd_ptr_q + 1'b1;
        state_d   = S_HOLD;
      end else if (rd_take) begin
        state_d = S_EMPTY;
      end
      usedw_d = usedw_q + {{widthad{1'b0}}, wr_acc} - {{widthad{1'b0}}, rd_take};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - directed and random bench for fifo_ram_ctrl with a behavioural RAM
module tb_fifo_ram_ctrl;
  localparam int W  = 8;
  localparam int WA = 2;

  logic          clk = 1'b0;
  logic          rst_n, sclr, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [W-1:0]  wr_data, rd_data, ram_data, ram_q;
  logic [WA:0]   usedw;
  logic          full, almost_full, ram_wren;
  logic [WA-1:0] ram_wraddress, ram_rdaddress;
  logic [W-1:0]  mem [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ram_ctrl #(.width(W), .widthad(WA), .afull_lvl(3)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .usedw(usedw), .full(full), .almost_full(almost_full),
    .ram_wraddress(ram_wraddress), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  initial for (int i = 0; i < 4; i++) mem[i] = '0;
  always @(posedge clk) if (ram_wren) mem[ram_wraddress] <= ram_data;
  assign ram_q = mem[ram_rdaddress];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic [W-1:0] exp);
    int n = 0;
    rd_ready = 1'b1;
    #1;
    while (!rd_valid && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (!rd_valid || rd_data !== exp) begin
      failures++;
      $display("FAIL read_order: rd_valid=%0b rd_data=%02h required %02h", rd_valid, rd_data, exp);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (usedw !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0 || ram_wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: usedw=%0d rd_valid=%0b wr_ready=%0b full=%0b afull=%0b wren=%0b required 0 0 1 0 0 0",
               usedw, rd_valid, wr_ready, full, almost_full, ram_wren);
    end
    step();
    wr_valid = 1'b1; wr_data = 8'h55;
    step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || usedw !== 3'd0 || wr_ready !== 1'b1 || ram_wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_midtraffic: rd_valid=%0b usedw=%0d wr_ready=%0b wren=%0b required 0 0 1 0",
               rd_valid, usedw, wr_ready, ram_wren);
    end
    step();
    rst_n = 1'b1; wr_valid = 1'b1; wr_data = 8'h66;
    #1;
    checks++;
    if (ram_wraddress !== 2'd0 || ram_wren !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_write: wraddress=%0d wren=%0b required 0 1", ram_wraddress, ram_wren);
    end
    step();
    wr_valid = 1'b0;
    expect_read(8'h66);
    rd_ready = 1'b0;
  endtask

  task automatic test_single_word();
    step();
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'hA1;
    #1;
    checks++;
    if (usedw !== 3'd0 || ram_wren !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_c0: usedw=%0d wren=%0b rd_valid=%0b required 0 1 0", usedw, ram_wren, rd_valid);
    end
    step();
    wr_valid = 1'b0;
    #1;
    checks++;
    if (usedw !== 3'd1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_c1: usedw=%0d rd_valid=%0b required 1 0", usedw, rd_valid);
    end
    step();
    #1;
    checks++;
    if (usedw !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 8'hA1) begin
      failures++;
      $display("FAIL single_c2: usedw=%0d rd_valid=%0b rd_data=%02h required 1 1 a1", usedw, rd_valid, rd_data);
    end
    step();
    #1;
    checks++;
    if (usedw !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_c3: usedw=%0d rd_valid=%0b required 0 0", usedw, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_fill();
    step();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'h10 + W'(i);
      #1;
      checks++;
      if (wr_ready !== 1'b1 || usedw !== 3'(i) || almost_full !== (i >= 3)) begin
        failures++;
        $display("FAIL fill_accept%0d: wr_ready=%0b usedw=%0d afull=%0b required 1 %0d %0b",
                 i, wr_ready, usedw, almost_full, i, (i >= 3));
      end
      step();
    end
    wr_data = 8'h15;
    #1;
    checks++;
    if (wr_ready !== 1'b0 || full !== 1'b1 || usedw !== 3'd5 || almost_full !== 1'b1 ||
        rd_valid !== 1'b1 || rd_data !== 8'h10) begin
      failures++;
      $display("FAIL fill_full: wr_ready=%0b full=%0b usedw=%0d afull=%0b rd_valid=%0b rd_data=%02h required 0 1 5 1 1 10",
               wr_ready, full, usedw, almost_full, rd_valid, rd_data);
    end
    step();
    #1;
    checks++;
    if (wr_ready !== 1'b0 || rd_data !== 8'h10 || ram_wren !== 1'b0) begin
      failures++;
      $display("FAIL fill_hold: wr_ready=%0b rd_data=%02h wren=%0b required 0 10 0", wr_ready, rd_data, ram_wren);
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || ram_wren !== 1'b1 || usedw !== 3'd4 || rd_data !== 8'h11) begin
      failures++;
      $display("FAIL fill_after_pulse: wr_ready=%0b wren=%0b usedw=%0d rd_data=%02h required 1 1 4 11",
               wr_ready, ram_wren, usedw, rd_data);
    end
    step();
    wr_valid = 1'b0;
    #1;
    checks++;
    if (usedw !== 3'd5) begin
      failures++;
      $display("FAIL fill_refull: usedw=%0d required 5", usedw);
    end
    for (int i = 1; i < 6; i++) expect_read(8'h10 + W'(i));
    #1;
    checks++;
    if (usedw !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_drained: usedw=%0d rd_valid=%0b required 0 0", usedw, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    step();
    rd_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      wr_valid = (k < 12); wr_data = W'(k);
      #1;
      checks++;
      if ((k < 12 && wr_ready !== 1'b1) || usedw > 3'd2) begin
        failures++;
        $display("FAIL wrap_cycle%0d: wr_ready=%0b usedw=%0d required 1 <=2", k, wr_ready, usedw);
      end
      if (k >= 2) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== W'(k - 2)) begin
          failures++;
          $display("FAIL wrap_read%0d: rd_valid=%0b rd_data=%02h required 1 %02h", k, rd_valid, rd_data, k - 2);
        end
      end
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_sclr();
    step();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'h20 + W'(i);
      step();
    end
    sclr = 1'b1; wr_data = 8'h77;
    #1;
    checks++;
    if (usedw !== 3'd3 || ram_wren !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL sclr_cycle: usedw=%0d wren=%0b wr_ready=%0b required 3 0 0", usedw, ram_wren, wr_ready);
    end
    step();
    sclr = 1'b0; wr_valid = 1'b0;
    #1;
    checks++;
    if (usedw !== 3'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL sclr_after: usedw=%0d rd_valid=%0b required 0 0", usedw, rd_valid);
    end
    step();
    wr_valid = 1'b1; wr_data = 8'h88;
    #1;
    checks++;
    if (ram_wraddress !== 2'd0 || ram_wren !== 1'b1) begin
      failures++;
      $display("FAIL sclr_first_write: wraddress=%0d wren=%0b required 0 1", ram_wraddress, ram_wren);
    end
    step();
    wr_valid = 1'b0;
    expect_read(8'h88);
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sb[$];
    logic [W-1:0] exp, prev_data;
    logic         prev_hold = 1'b0;
    int           sent = 0, rcvd = 0, cyc = 0;
    step();
    while (rcvd < 200 && cyc < 5000) begin
      wr_valid = (sent < 200) && ($urandom_range(0, 1) == 1);
      wr_data  = W'($urandom);
      rd_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (prev_hold) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          failures++;
          $display("FAIL stall_stable: rd_valid=%0b rd_data=%02h required 1 %02h", rd_valid, rd_data, prev_data);
        end
      end
      if (wr_valid && wr_ready) begin
        sb.push_back(wr_data);
        sent++;
      end
      if (rd_valid && rd_ready) begin
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        if (rd_data !== exp) begin
          failures++;
          $display("FAIL random_order%0d: rd_data=%02h required %02h", rcvd, rd_data, exp);
        end
        rcvd++;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      step();
      cyc++;
    end
    checks++;
    if (rcvd != 200) begin
      failures++;
      $display("FAIL random_complete: received %0d words required 200", rcvd);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_wrap();
    test_sclr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
